// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : laser_pkg
// Purpose  : Shared constants and helpers for the laser shot/bomb schedulers.
// Revision : 1.0 - initial release
// ============================================================================
package laser_pkg;

    localparam int NUM_SLOTS     = 4;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int X_W           = 10;

    typedef enum logic {
        OWNER_PLAYER = 1'b0,
        OWNER_ALIEN  = 1'b1
    } owner_e;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_pick.sv
`default_nettype none
// ============================================================================
// Module   : slot_pick
// Purpose  : Lowest-index free slot priority encoder (one-hot + any_free).
// Revision : 1.0 - initial release
// ============================================================================
module slot_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] slot_busy,
    output logic [N-1:0] free_onehot,
    output logic         any_free
);

    // ~x & (x+1) isolates the lowest zero bit; all-busy wraps to zero.
    always_comb begin
        free_onehot = ~slot_busy & (slot_busy + N'(1));
        any_free    = ~&slot_busy;
    end

endmodule
`default_nettype wire

// File: rtl/laser_shot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : laser_shot_scheduler
// Purpose  : Arbitrates player/alien shots into a shared laser slot pool.
// Revision : 1.0 - initial release
// ============================================================================
module laser_shot_scheduler #(
    parameter int NUM_SLOTS        = laser_pkg::NUM_SLOTS,
    parameter int PLAYER_MAX_SHOTS = 1,
    parameter int PLAYER_COOLDOWN  = 8,
    parameter int ALIEN_COOLDOWN   = 30,
    parameter int MOVE_DIV         = 100000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_tick,
    input  logic                      player_fire,
    input  logic [laser_pkg::X_W-1:0] player_x,
    input  logic                      alien_req,
    input  logic [laser_pkg::X_W-1:0] alien_x,
    input  logic [NUM_SLOTS-1:0]      slot_done,
    output logic [NUM_SLOTS-1:0]      fire,
    output logic [laser_pkg::X_W-1:0] fire_x,
    output logic [NUM_SLOTS-1:0]      slot_busy,
    output logic [NUM_SLOTS-1:0]      slot_owner,
    output logic                      alien_grant,
    output logic                      move_tick
);
    import laser_pkg::*;

    localparam int PCD_W = (PLAYER_COOLDOWN > 0) ? $clog2(PLAYER_COOLDOWN + 1) : 1;
    localparam int ACD_W = (ALIEN_COOLDOWN > 0) ? $clog2(ALIEN_COOLDOWN + 1) : 1;
    localparam int MV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [PCD_W-1:0] PCD_LOAD = PCD_W'(PLAYER_COOLDOWN);
    localparam logic [ACD_W-1:0] ACD_LOAD = ACD_W'(ALIEN_COOLDOWN);
    localparam logic [MV_W-1:0]  MV_LAST  = MV_W'(MOVE_DIV - 1);

    logic                 prev_fire_q, prev_fire_d;
    logic                 pending_q, pending_d;
    logic [PCD_W-1:0]     pcd_q, pcd_d;
    logic [ACD_W-1:0]     acd_q, acd_d;
    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic [NUM_SLOTS-1:0] owner_q, owner_d;
    logic [NUM_SLOTS-1:0] fire_q, fire_d;
    logic [X_W-1:0]       fire_x_q, fire_x_d;
    logic                 grant_q, grant_d;
    logic [MV_W-1:0]      mv_cnt_q, mv_cnt_d;
    logic                 move_tick_q, move_tick_d;

    logic [NUM_SLOTS-1:0] w_free;
    logic                 w_any_free;
    logic                 w_press;
    logic                 w_player_go;
    logic                 w_alien_go;
    int                   w_player_cnt;
    int                   w_alien_cnt;

    slot_pick #(
        .N (NUM_SLOTS)
    ) u_slot_pick (
        .slot_busy   (busy_q),
        .free_onehot (w_free),
        .any_free    (w_any_free)
    );

    always_comb begin
        w_press      = player_fire & ~prev_fire_q;
        w_player_cnt = popcount(32'(busy_q & ~owner_q));
        w_alien_cnt  = popcount(32'(busy_q & owner_q));
        w_player_go  = pending_q && (pcd_q == '0) &&
                       (w_player_cnt < PLAYER_MAX_SHOTS) && w_any_free;
        // One slot always stays out of reach of the aliens.
        w_alien_go   = !w_player_go && alien_req && (acd_q == '0) &&
                       (w_alien_cnt < NUM_SLOTS - 1) && w_any_free;

        prev_fire_d = player_fire;
        pending_d   = w_press | (pending_q & ~w_player_go);
        busy_d      = busy_q & ~slot_done;
        owner_d     = owner_q;
        fire_d      = '0;
        fire_x_d    = fire_x_q;
        grant_d     = 1'b0;

        if (w_player_go) begin
            busy_d   = busy_d | w_free;
            owner_d  = owner_q & ~w_free;
            fire_d   = w_free;
            fire_x_d = player_x;
        end else if (w_alien_go) begin
            busy_d   = busy_d | w_free;
            owner_d  = owner_q | w_free;
            fire_d   = w_free;
            fire_x_d = alien_x;
            grant_d  = 1'b1;
        end

        pcd_d = pcd_q;
        if (w_player_go) begin
            pcd_d = PCD_LOAD;
        end else if (frame_tick && (pcd_q != '0)) begin
            pcd_d = pcd_q - PCD_W'(1);
        end

        acd_d = acd_q;
        if (w_alien_go) begin
            acd_d = ACD_LOAD;
        end else if (frame_tick && (acd_q != '0)) begin
            acd_d = acd_q - ACD_W'(1);
        end

        mv_cnt_d    = (mv_cnt_q == MV_LAST) ? '0 : mv_cnt_q + MV_W'(1);
        move_tick_d = (mv_cnt_d == MV_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_fire_q <= 1'b1;
            pending_q   <= 1'b0;
            pcd_q       <= '0;
            acd_q       <= '0;
            busy_q      <= '0;
            owner_q     <= '0;
            fire_q      <= '0;
            fire_x_q    <= '0;
            grant_q     <= 1'b0;
            mv_cnt_q    <= '0;
            move_tick_q <= 1'b0;
        end else begin
            prev_fire_q <= prev_fire_d;
            pending_q   <= pending_d;
            pcd_q       <= pcd_d;
            acd_q       <= acd_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            fire_q      <= fire_d;
            fire_x_q    <= fire_x_d;
            grant_q     <= grant_d;
            mv_cnt_q    <= mv_cnt_d;
            move_tick_q <= move_tick_d;
        end
    end

    assign fire        = fire_q;
    assign fire_x      = fire_x_q;
    assign slot_busy   = busy_q;
    assign slot_owner  = owner_q;
    assign alien_grant = grant_q;
    assign move_tick   = move_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_laser_shot_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_laser_shot_scheduler
// Purpose  : Randomized + directed bench against a behavioural slot-pool model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_shot_scheduler;

    localparam int N    = 4;
    localparam int PMAX = 1;
    localparam int PCD  = 8;
    localparam int ACD  = 2;
    localparam int MD   = 4;

    logic         clk         = 1'b0;
    logic         reset_n     = 1'b0;
    logic         frame_tick  = 1'b0;
    logic         player_fire = 1'b1;
    logic [9:0]   player_x    = 10'd320;
    logic         alien_req   = 1'b0;
    logic [9:0]   alien_x     = 10'd0;
    logic [N-1:0] slot_done   = '0;
    logic [N-1:0] fire;
    logic [9:0]   fire_x;
    logic [N-1:0] slot_busy;
    logic [N-1:0] slot_owner;
    logic         alien_grant;
    logic         move_tick;

    laser_shot_scheduler #(
        .NUM_SLOTS        (N),
        .PLAYER_MAX_SHOTS (PMAX),
        .PLAYER_COOLDOWN  (PCD),
        .ALIEN_COOLDOWN   (ACD),
        .MOVE_DIV         (MD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .player_fire (player_fire),
        .player_x    (player_x),
        .alien_req   (alien_req),
        .alien_x     (alien_x),
        .slot_done   (slot_done),
        .fire        (fire),
        .fire_x      (fire_x),
        .slot_busy   (slot_busy),
        .slot_owner  (slot_owner),
        .alien_grant (alien_grant),
        .move_tick   (move_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: pool of slots with owners, two cooldown counters,
    // one pending flag and a modulo frame counter for the motion tick.
    int m_busy[N];
    int m_owner[N];
    int m_pend, m_prev, m_pcd, m_acd, m_cnt;
    int e_fire_idx, e_fire_x, e_grant, e_move;

    always @(posedge clk) begin : model_b
        int  press, pn, an, free;
        bit  pg, ag;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i]  = 0;
                m_owner[i] = 0;
            end
            m_pend = 0; m_prev = 1; m_pcd = 0; m_acd = 0; m_cnt = 0;
            e_fire_idx = -1; e_fire_x = 0; e_grant = 0; e_move = 0;
        end else begin
            press  = (player_fire && !m_prev) ? 1 : 0;
            m_prev = player_fire ? 1 : 0;
            pn = 0; an = 0; free = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_busy[i] != 0) begin
                    if (m_owner[i] != 0) an++; else pn++;
                end else begin
                    free = i;
                end
            end
            pg = (m_pend != 0) && (m_pcd == 0) && (pn < PMAX) && (free >= 0);
            ag = !pg && alien_req && (m_acd == 0) && (an < N - 1) && (free >= 0);
            for (int i = 0; i < N; i++) if (slot_done[i]) m_busy[i] = 0;
            e_fire_idx = -1;
            e_grant    = 0;
            if (pg) begin
                m_busy[free] = 1; m_owner[free] = 0;
                e_fire_idx = free; e_fire_x = int'(player_x); m_pcd = PCD;
            end else if (frame_tick && m_pcd > 0) begin
                m_pcd--;
            end
            if (ag) begin
                m_busy[free] = 1; m_owner[free] = 1;
                e_fire_idx = free; e_fire_x = int'(alien_x); e_grant = 1; m_acd = ACD;
            end else if (frame_tick && m_acd > 0) begin
                m_acd--;
            end
            if (press != 0) m_pend = 1;
            else if (pg) m_pend = 0;
            m_cnt  = (m_cnt + 1) % MD;
            e_move = (m_cnt == MD - 1) ? 1 : 0;
        end
    end

    always @(negedge clk) begin : compare_b
        logic [N-1:0] ef, eb, eo;
        if (check_en) begin
            ef = '0;
            if (e_fire_idx >= 0) ef[e_fire_idx] = 1'b1;
            for (int i = 0; i < N; i++) begin
                eb[i] = (m_busy[i] != 0);
                eo[i] = (m_busy[i] != 0) && (m_owner[i] != 0);
            end
            check("m_fire", 32'(fire), 32'(ef));
            check("m_fire_x", 32'(fire_x), e_fire_x);
            check("m_busy", 32'(slot_busy), 32'(eb));
            check("m_owner", 32'(slot_owner & slot_busy), 32'(eo));
            check("m_grant", 32'(alien_grant), e_grant);
            check("m_move", 32'(move_tick), e_move);
        end
    end

    initial begin
        // Button held through reset must not fire.
        step(3);
        check_en = 1'b1;
        reset_n  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("held_nofire", 32'(fire), 0);
        end
        player_fire = 1'b0;
        step(1);
        player_fire = 1'b1;
        step(1);
        check("press_early", 32'(fire), 0);
        step(1);
        check("press_fire", 32'(fire), 32'h1);
        check("press_x", 32'(fire_x), 320);
        check("press_owner", 32'(slot_owner[0]), 0);
        step(1);
        check("press_pulse", 32'(fire), 0);

        // In-flight limit plus cooldown expiry.
        player_fire = 1'b0;
        step(1);
        player_fire = 1'b1;
        step(1);
        player_fire = 1'b0;
        step(2);
        slot_done = 4'b0001;
        step(1);
        slot_done = '0;
        step(1);
        check("release0", 32'(slot_busy), 0);
        for (int k = 1; k <= 8; k++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(1);
            check("cooldown_fire", 32'(fire), (k == 8) ? 32'h1 : 32'h0);
        end

        // Mid-flight reset, then simultaneous player/alien requests.
        reset_n = 1'b0;
        step(2);
        check("reset_busy", 32'(slot_busy), 0);
        check("reset_fire", 32'(fire), 0);
        reset_n = 1'b1;
        step(1);
        player_fire = 1'b1;
        step(1);
        alien_x   = 10'd100;
        alien_req = 1'b1;
        step(1);
        check("simul_player", 32'(fire), 32'h1);
        check("simul_nogrant", 32'(alien_grant), 0);
        step(1);
        check("simul_alien", 32'(fire), 32'h2);
        check("simul_grant", 32'(alien_grant), 1);
        check("simul_x", 32'(fire_x), 100);
        check("simul_owner", 32'(slot_owner[1]), 1);

        // Alien reservation leaves one slot for the player.
        slot_done = 4'b0001;
        step(1);
        slot_done = '0;
        for (int k = 0; k < 40; k++) begin
            frame_tick = (k % 2 == 0);
            step(1);
        end
        frame_tick = 1'b0;
        check("resv_busy", 32'(slot_busy), 32'h7);
        check("resv_owner", 32'(slot_owner), 32'h7);
        player_fire = 1'b0;
        step(1);
        player_fire = 1'b1;
        step(2);
        check("resv_player", 32'(fire), 32'h8);
        check("resv_powner", 32'(slot_owner[3]), 0);

        // Release and reuse.
        slot_done = 4'b0010;
        step(1);
        slot_done = '0;
        check("reuse_free", 32'(slot_busy), 32'hD);
        step(1);
        check("reuse_fire", 32'(fire), 32'h2);
        check("reuse_grant", 32'(alien_grant), 1);
        alien_req = 1'b0;
        step(1);
        slot_done = 4'b0100;
        step(1);
        slot_done = '0;
        check("free2", 32'(slot_busy), 32'hB);
        slot_done = 4'b0100;
        step(1);
        slot_done = '0;
        check("done_idle", 32'(slot_busy), 32'hB);
        check("done_idle_fire", 32'(fire), 0);

        // Motion tick cadence after reset.
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1);
            check("move_tick", 32'(move_tick), ((k + 1) % 4 == 3) ? 32'h1 : 32'h0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(1);
            reset_n    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) player_fire = ~player_fire;
            alien_req  = ($urandom_range(0, 2) != 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            player_x   = 10'($urandom);
            alien_x    = 10'($urandom);
            for (int i = 0; i < N; i++) slot_done[i] = ($urandom_range(0, 9) == 0);
        end
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
